// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer and the external ALU:
// opcodes, one-hot ALU operation flags, FSM state encoding and the
// latched ALU context carried from acceptance through capture.
package alu_sequencer_pkg;

  // Command opcodes as presented on cmdOp.
  localparam logic [2:0] OP_NOT = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  // One-hot operation flags understood by the ALU.
  localparam logic [5:0] FLAG_NONE = 6'b000000;
  localparam logic [5:0] FLAG_NOT  = 6'b000001;
  localparam logic [5:0] FLAG_OR   = 6'b000010;
  localparam logic [5:0] FLAG_AND  = 6'b000100;
  localparam logic [5:0] FLAG_ADD  = 6'b001000;
  localparam logic [5:0] FLAG_SUB  = 6'b010000;
  localparam logic [5:0] FLAG_XOR  = 6'b100000;

  // Sequencer FSM state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Everything the ALU needs, frozen at command acceptance so that a
  // destination that aliases a source still sees the pre-write value.
  typedef struct packed {
    logic [2:0] op;
    logic       use_carry;
    logic [7:0] a;
    logic [7:0] b;
  } alu_ctx_t;

  // Map an opcode to the ALU one-hot flag; LDI/reserved never reach the ALU.
  function automatic logic [5:0] op_flag(input logic [2:0] op);
    case (op)
      OP_NOT:  return FLAG_NOT;
      OP_OR:   return FLAG_OR;
      OP_AND:  return FLAG_AND;
      OP_ADD:  return FLAG_ADD;
      OP_SUB:  return FLAG_SUB;
      OP_XOR:  return FLAG_XOR;
      OP_LDI:  return FLAG_NONE;
      OP_RSV:  return FLAG_NONE;
      default: return FLAG_NONE;
    endcase
  endfunction

  // ADD and SUB are the only operations that consume and update carry.
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// General register file: NREGS x 8-bit, one synchronous write port and
// three combinational read ports (two operand sources, one debug read).
module alu_regfile #(
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [7:0]               i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  output logic [7:0]               o_rdata_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [7:0]               o_rdata_b,
  input  logic [$clog2(NREGS)-1:0] i_raddr_c,
  output logic [7:0]               o_rdata_c
);

  logic [7:0] r_regs [NREGS];

  // Register storage: cleared on reset, otherwise written when enabled.
  // NOTE: non-blocking (<=) for all clocked state so every flop samples pre-edge values.
  // NOTE: the array is reset explicitly because software expects registers to read 0x00
  //       after reset; this rules out a RAM macro but the file is only a few bytes.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];
  assign o_rdata_c = r_regs[i_raddr_c];

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU. Accepts one
// command at a time in IDLE, drives the ALU for two cycles (ISSUE,
// CAPTURE), writes the result back and reports it for one cycle in DONE.
// LDI and the reserved opcode skip the ALU and go straight to DONE.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  // Command channel
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic [2:0]               cmdOp,
  input  logic [$clog2(NREGS)-1:0] cmdDst,
  input  logic [$clog2(NREGS)-1:0] cmdSrcA,
  input  logic [$clog2(NREGS)-1:0] cmdSrcB,
  input  logic [7:0]               cmdImm,
  input  logic                     cmdUseCarry,
  // ALU interface
  output logic [7:0]               aluA1,
  output logic [7:0]               aluA2,
  output logic [5:0]               aluOpFlag,
  output logic                     aluEFlag,
  output logic                     aluCin,
  input  logic [7:0]               aluOut,
  input  logic                     aluCout,
  // Response channel
  output logic                     rspValid,
  output logic [7:0]               rspData,
  output logic                     rspCarry,
  output logic                     rspErr,
  // Debug register read
  input  logic [$clog2(NREGS)-1:0] rdAddr,
  output logic [7:0]               rdData
);

  localparam int AW = $clog2(NREGS);

  logic [1:0]    r_state;
  alu_ctx_t      r_ctx;
  logic [AW-1:0] r_dst;
  logic          r_carry;
  logic [7:0]    r_rsp_data;
  logic          r_rsp_err;

  logic          w_accept;
  logic          w_active;
  logic          w_done;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;
  logic [7:0]    w_src_a;
  logic [7:0]    w_src_b;

  // Ready only in IDLE and never while reset is asserted.
  assign cmdReady = (r_state == ST_IDLE) && rstN;
  assign w_accept = cmdValid && cmdReady;
  assign w_active = (r_state == ST_ISSUE) || (r_state == ST_CAPTURE);
  assign w_done   = (r_state == ST_DONE);

  // Write-port steering: ALU result at the end of CAPTURE, immediate on LDI acceptance.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_dst;
    w_wdata = aluOut;
    if (r_state == ST_CAPTURE) begin
      w_we = 1'b1;
    end else if (w_accept && (cmdOp == OP_LDI)) begin
      w_we    = 1'b1;
      w_waddr = cmdDst;
      w_wdata = cmdImm;
    end
  end

  alu_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rstN      (rstN),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (cmdSrcA),
    .o_rdata_a (w_src_a),
    .i_raddr_b (cmdSrcB),
    .o_rdata_b (w_src_b),
    .i_raddr_c (rdAddr),
    .o_rdata_c (rdData)
  );

  // Sequencer FSM plus the context, carry flag and response registers it owns.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= ST_IDLE;
      r_ctx      <= '0;
      r_dst      <= '0;
      r_carry    <= 1'b0;
      r_rsp_data <= 8'h00;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmdValid) begin
            // Sources are captured here so later writes cannot disturb them.
            r_ctx.op        <= cmdOp;
            r_ctx.use_carry <= cmdUseCarry;
            r_ctx.a         <= w_src_a;
            r_ctx.b         <= w_src_b;
            r_dst           <= cmdDst;
            r_rsp_err       <= 1'b0;
            case (cmdOp)
              OP_LDI: begin
                r_rsp_data <= cmdImm;
                r_state    <= ST_DONE;
              end
              OP_RSV: begin
                r_rsp_data <= 8'h00;
                r_rsp_err  <= 1'b1;
                r_state    <= ST_DONE;
              end
              default: r_state <= ST_ISSUE;
            endcase
          end
        end
        ST_ISSUE: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_rsp_data <= aluOut;
          if (op_is_arith(r_ctx.op)) begin
            r_carry <= aluCout;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ALU drive is quiet outside ISSUE/CAPTURE so the ALU sees no stray enables.
  assign aluA1     = w_active ? r_ctx.a : 8'h00;
  assign aluA2     = w_active ? r_ctx.b : 8'h00;
  assign aluOpFlag = w_active ? op_flag(r_ctx.op) : FLAG_NONE;
  assign aluEFlag  = w_active;
  assign aluCin    = r_ctx.use_carry && op_is_arith(r_ctx.op) && r_carry;

  // Response fields are held at zero except during the single DONE cycle.
  assign rspValid = w_done;
  assign rspData  = w_done ? r_rsp_data : 8'h00;
  assign rspErr   = w_done && r_rsp_err;
  assign rspCarry = w_done && r_carry;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios followed by
// randomized commands, compared against an array-based reference model.
// The bench also plays the external ALU.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       cmdValid = 1'b0;
  logic       cmdReady;
  logic [2:0] cmdOp = 3'd0;
  logic [1:0] cmdDst = 2'd0;
  logic [1:0] cmdSrcA = 2'd0;
  logic [1:0] cmdSrcB = 2'd0;
  logic [7:0] cmdImm = 8'h00;
  logic       cmdUseCarry = 1'b0;
  logic [7:0] aluA1;
  logic [7:0] aluA2;
  logic [5:0] aluOpFlag;
  logic       aluEFlag;
  logic       aluCin;
  logic [7:0] aluOut;
  logic       aluCout;
  logic       rspValid;
  logic [7:0] rspData;
  logic       rspCarry;
  logic       rspErr;
  logic [1:0] rdAddr = 2'd0;
  logic [7:0] rdData;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] m_regs [4];
  logic       m_carry;

  alu_sequencer #(.NREGS(4)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .cmdValid    (cmdValid),
    .cmdReady    (cmdReady),
    .cmdOp       (cmdOp),
    .cmdDst      (cmdDst),
    .cmdSrcA     (cmdSrcA),
    .cmdSrcB     (cmdSrcB),
    .cmdImm      (cmdImm),
    .cmdUseCarry (cmdUseCarry),
    .aluA1       (aluA1),
    .aluA2       (aluA2),
    .aluOpFlag   (aluOpFlag),
    .aluEFlag    (aluEFlag),
    .aluCin      (aluCin),
    .aluOut      (aluOut),
    .aluCout     (aluCout),
    .rspValid    (rspValid),
    .rspData     (rspData),
    .rspCarry    (rspCarry),
    .rspErr      (rspErr),
    .rdAddr      (rdAddr),
    .rdData      (rdData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ALU behaviour in plain arithmetic; bit 8 is carry (ADD) or borrow (SUB).
  function automatic logic [8:0] alu_eval(input int op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
    int s;
    case (op)
      0: return {1'b0, ~a};
      1: return {1'b0, a | b};
      2: return {1'b0, a & b};
      3: begin
        s = int'(a) + int'(b) + int'(cin);
        return {s > 255, s[7:0]};
      end
      4: begin
        s = int'(a) - int'(b) - int'(cin);
        return {s < 0, s[7:0]};
      end
      5: return {1'b0, a ^ b};
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [5:0] flag_of(input int op);
    return 6'(1 << op);
  endfunction

  // External ALU model driven by the one-hot flag.
  int alu_idx;
  always_comb begin
    alu_idx = -1;
    for (int i = 0; i < 6; i++) begin
      if (aluOpFlag == flag_of(i)) alu_idx = i;
    end
    if (alu_idx >= 0) {aluCout, aluOut} = alu_eval(alu_idx, aluA1, aluA2, aluCin);
    else              {aluCout, aluOut} = 9'h000;
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_carry = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rdAddr = 2'(i);
      #1;
      check(tag, 32'(rdData), 32'(m_regs[i]));
    end
  endtask

  // Issue one command and check ALU drive, latency, response and writeback.
  // hold=1 keeps cmdValid asserted with scrambled fields until DONE.
  task automatic run_cmd(input int op, input int dst, input int sa, input int sb,
                         input logic [7:0] imm, input logic uc, input bit hold);
    logic [7:0] a, b, exp_data;
    logic       cin, exp_err, exp_carry;
    logic [8:0] r;
    int         exp_lat;
    bit         got, rdy;

    a        = m_regs[sa];
    b        = m_regs[sb];
    cin      = (uc && (op == 3 || op == 4)) ? m_carry : 1'b0;
    exp_err  = 1'b0;
    exp_carry = m_carry;
    exp_lat  = (op <= 5) ? 3 : 1;
    if (op <= 5) begin
      r        = alu_eval(op, a, b, cin);
      exp_data = r[7:0];
      if (op == 3 || op == 4) exp_carry = r[8];
    end else if (op == 6) begin
      exp_data = imm;
    end else begin
      exp_data = 8'h00;
      exp_err  = 1'b1;
    end

    rdy = 1'b0;
    for (int w = 0; w < 8 && !rdy; w++) begin
      @(negedge clk);
      rdy = cmdReady;
    end
    check("cmd_ready_wait", 32'(rdy), 32'd1);
    if (!rdy) return;
    check("idle_eflag", 32'(aluEFlag), 32'd0);
    check("idle_opflag", 32'(aluOpFlag), 32'd0);

    cmdValid    = 1'b1;
    cmdOp       = 3'(op);
    cmdDst      = 2'(dst);
    cmdSrcA     = 2'(sa);
    cmdSrcB     = 2'(sb);
    cmdImm      = imm;
    cmdUseCarry = uc;
    @(posedge clk);

    got = 1'b0;
    for (int k = 1; k <= 6 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy_ready", 32'(cmdReady), 32'd0);
        if (op <= 5) begin
          check("issue_a1", 32'(aluA1), 32'(a));
          check("issue_a2", 32'(aluA2), 32'(b));
          check("issue_opflag", 32'(aluOpFlag), 32'(flag_of(op)));
          check("issue_eflag", 32'(aluEFlag), 32'd1);
          check("issue_cin", 32'(aluCin), 32'(cin));
        end
      end
      if (rspValid) begin
        got = 1'b1;
        check("rsp_latency", 32'(k), 32'(exp_lat));
        check("rsp_data", 32'(rspData), 32'(exp_data));
        check("rsp_err", 32'(rspErr), 32'(exp_err));
        check("rsp_carry", 32'(rspCarry), 32'(exp_carry));
        cmdValid = 1'b0;
      end else if (hold) begin
        cmdOp       = 3'($urandom_range(0, 7));
        cmdDst      = 2'($urandom_range(0, 3));
        cmdSrcA     = 2'($urandom_range(0, 3));
        cmdSrcB     = 2'($urandom_range(0, 3));
        cmdImm      = 8'($urandom_range(0, 255));
        cmdUseCarry = 1'($urandom_range(0, 1));
      end else begin
        cmdValid = 1'b0;
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
    cmdValid = 1'b0;

    if (op <= 6) m_regs[dst] = exp_data;
    m_carry = exp_carry;

    @(negedge clk);
    check("rsp_single_pulse", 32'(rspValid), 32'd0);
    rdAddr = 2'($urandom_range(0, 3));
    #1;
    check("rd_after_cmd", 32'(rdData), 32'(m_regs[rdAddr]));
  endtask

  // Reset asserted during CAPTURE of XOR r0 = r0 ^ r1 must abort cleanly.
  task automatic reset_mid_xor();
    @(negedge clk);
    check("pre_xor_ready", 32'(cmdReady), 32'd1);
    cmdValid = 1'b1;
    cmdOp    = 3'd5;
    cmdDst   = 2'd0;
    cmdSrcA  = 2'd0;
    cmdSrcB  = 2'd1;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    @(negedge clk);
    check("xor_capture_eflag", 32'(aluEFlag), 32'd1);
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_rsp_valid", 32'(rspValid), 32'd0);
    check("rst_eflag", 32'(aluEFlag), 32'd0);
    check("rst_opflag", 32'(aluOpFlag), 32'd0);
    check("rst_a1", 32'(aluA1), 32'd0);
    check("rst_cin", 32'(aluCin), 32'd0);
    check("rst_ready_low", 32'(cmdReady), 32'd0);
    check_regs("rst_regs");
    rstN = 1'b1;
    @(negedge clk);
    check("rst_no_late_rsp", 32'(rspValid), 32'd0);
    check("post_rst_ready", 32'(cmdReady), 32'd1);
  endtask

  initial begin
    model_reset();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(cmdReady), 32'd0);
    check("reset_rsp_valid", 32'(rspValid), 32'd0);
    check("reset_rsp_data", 32'(rspData), 32'd0);
    check("reset_a1", 32'(aluA1), 32'd0);
    check("reset_a2", 32'(aluA2), 32'd0);
    check("reset_opflag", 32'(aluOpFlag), 32'd0);
    check("reset_eflag", 32'(aluEFlag), 32'd0);
    check("reset_cin", 32'(aluCin), 32'd0);
    check_regs("reset_regs");
    rstN = 1'b1;

    // Directed: carry generation, carry-in use, borrow, carry hold, error.
    run_cmd(6, 0, 0, 0, 8'hF0, 1'b0, 1'b0);
    run_cmd(6, 1, 0, 0, 8'h20, 1'b0, 1'b0);
    run_cmd(3, 2, 0, 1, 8'h00, 1'b0, 1'b0);   // 0xF0+0x20 = 0x10, carry 1
    check("dir_add_r2", 32'(m_regs[2]), 32'h10);
    run_cmd(3, 3, 1, 1, 8'h00, 1'b1, 1'b0);   // 0x20+0x20+1 = 0x41, carry 0
    run_cmd(4, 3, 1, 0, 8'h00, 1'b0, 1'b0);   // 0x20-0xF0 = 0x30, borrow 1
    run_cmd(2, 2, 0, 1, 8'h00, 1'b0, 1'b0);   // 0xF0&0x20 = 0x20, carry held
    run_cmd(7, 1, 0, 0, 8'hAA, 1'b0, 1'b0);   // reserved op
    run_cmd(3, 1, 1, 0, 8'h00, 1'b1, 1'b1);   // held cmdValid, dst aliases source
    run_cmd(6, 2, 0, 0, 8'h5C, 1'b0, 1'b1);   // held cmdValid on LDI
    check_regs("dir_regs");

    // Randomized command stream.
    for (int n = 0; n < 60; n++) begin
      run_cmd($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    check_regs("rand_regs");

    // Abort in CAPTURE, then confirm carry was cleared by reset.
    run_cmd(6, 0, 0, 0, 8'hF0, 1'b0, 1'b0);
    run_cmd(6, 1, 0, 0, 8'h20, 1'b0, 1'b0);
    run_cmd(3, 2, 0, 1, 8'h00, 1'b0, 1'b0);
    reset_mid_xor();
    run_cmd(6, 1, 0, 0, 8'h80, 1'b0, 1'b0);
    run_cmd(3, 3, 1, 1, 8'h00, 1'b1, 1'b0);   // cin must be 0 after reset
    check_regs("final_regs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter NREGS, default 4, SHALL set the number of 8-bit general registers; address width is clog2(NREGS).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rstN  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 cmdValid  input  1  SHALL mark a valid command.
REQ-005 cmdReady  output  1  SHALL indicate the command is accepted this cycle.
REQ-006 cmdOp  input  3  SHALL select the operation: 0 NOT, 1 OR, 2 AND, 3 ADD, 4 SUB, 5 XOR, 6 LDI, 7 reserved.
REQ-007 cmdDst, cmdSrcA, cmdSrcB  input  clog2(NREGS) each  SHALL be the destination and source register indices.
REQ-008 cmdImm  input  8  SHALL be the LDI immediate.
REQ-009 cmdUseCarry  input  1  SHALL select the stored carry flag as ALU carry-in for ADD/SUB.
REQ-010 aluA1, aluA2  output  8 each  SHALL drive the ALU operands.
REQ-011 aluOpFlag  output  6  SHALL drive the ALU one-hot op flag (NOT 000001, OR 000010, AND 000100, ADD 001000, SUB 010000, XOR 100000).
REQ-012 aluEFlag  output  1  SHALL be the ALU result-enable.
REQ-013 aluCin  output  1  SHALL be the ALU carry-in.
REQ-014 aluOut  input  8, aluCout  input  1  SHALL be the ALU result and carry/borrow out.
REQ-015 rspValid  output  1  SHALL pulse one cycle per completed command; no backpressure.
REQ-016 rspData  output  8, rspCarry  output  1, rspErr  output  1  SHALL be valid while rspValid=1.
REQ-017 rdAddr  input  clog2(NREGS), rdData  output  8  SHALL give combinational read of any register.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE, DONE; cmdReady=1 only in IDLE.
REQ-019 Acceptance (cmdValid and cmdReady at edge T) SHALL latch op, indices, cmdUseCarry and the two source register values.
REQ-020 Ops 0-5 SHALL go IDLE->ISSUE(T+1)->CAPTURE(T+2)->DONE(T+3)->IDLE.
REQ-021 In ISSUE and CAPTURE, aluA1/aluA2 SHALL carry the latched source values, aluOpFlag the one-hot code, aluEFlag=1; in IDLE and DONE aluOpFlag=000000, aluEFlag=0.
REQ-022 aluCin SHALL equal carry flag when cmdUseCarry=1 and op is ADD/SUB, else 0.
REQ-023 At the end of CAPTURE, aluOut SHALL be written to Dst; carry flag SHALL take aluCout for ADD/SUB only, else hold.
REQ-024 LDI SHALL write cmdImm to Dst at the acceptance edge and go IDLE->DONE; carry unchanged.
REQ-025 Op 7 SHALL go IDLE->DONE with rspErr=1, no register or carry change.
REQ-026 In DONE, rspValid=1, rspData=value written (0 on error), rspCarry=current carry flag.
REQ-027 Dst equal to a source SHALL use the pre-write source value (latched at acceptance).
REQ-028 cmdValid held while not IDLE SHALL not be accepted and SHALL not alter state; inputs are sampled only on acceptance.
REQ-029 Back-to-back: new command acceptable in the cycle after DONE; throughput 1 per 4 cycles (ALU ops), 1 per 2 (LDI/err).

Reset
REQ-030 rstN=0 at an edge SHALL force IDLE, all registers 0x00, carry 0, rspValid/rspErr/rspData/rspCarry 0, aluA1/aluA2 0x00, aluOpFlag 000000, aluEFlag 0, aluCin 0.
REQ-031 Reset mid-operation SHALL abort without writeback or response; cmdReady=0 during reset.

Structure
REQ-032 Opcode constants, one-hot op-flag constants and the FSM state encoding SHALL live in a shared package used by this block and the ALU.
REQ-033 The register file SHALL be one sub-module, alu_regfile (one write port, three combinational read ports).

Verification
REQ-034 LDI r0=0xF0, LDI r1=0x20, ADD r2=r0+r1 (useCarry=0) -> r2=0x10, rspCarry=1, rspValid exactly 3 cycles after ADD accept.
REQ-035 Carry=1, ADD r3=r1+r1 useCarry=1 -> aluCin=1, r3=0x41, rspCarry=0.
REQ-036 SUB r3=r1-r0 (0x20-0xF0) -> r3=0x30, rspCarry=1 (borrow); then AND r2=r0&r1 -> 0x20, carry stays 1.
REQ-037 cmdOp=7 -> rspErr=1, rspData=0x00, no register change; cmdValid held during a busy ADD -> no second acceptance until after DONE.
REQ-038 rstN=0 in CAPTURE of XOR r0=r0^r1 -> no rspValid, r0 reads 0x00, carry 0, state IDLE, aluEFlag 0 next cycle.
